// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : IF stage feeding the IF/ID pipeline register. Holds the fetch PC,
//            runs the instruction-memory read handshake, absorbs misses and
//            redirects that arrive while a miss is outstanding, and presents
//            PC / nextPC / Instruction / Insthit to IF/ID.
// Ports    :
//   clock            in   single clock, posedge
//   reset            in   synchronous, active-low
//   stall            in   downstream hold; PC must not advance
//   redirect         in   taken branch/jump from the ALU stage
//   redirect_target  in   [31:0] byte address to fetch after a redirect
//   imem_read        out  instruction-memory read request
//   imem_address     out  [31:0] fetch PC register
//   imem_readdata    in   [31:0] instruction word (valid on read & !busywait)
//   imem_busywait    in   miss in progress
//   PC               out  [31:0] address of the presented instruction
//   nextPC           out  [31:0] PC + PC_INC (wraps)
//   Instruction      out  [31:0] fetched word
//   Insthit          out  valid, correct-path instruction this cycle
//   fetch_busywait   out  holds the IF/ID register
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic [31:0] PC,
    output logic [31:0] nextPC,
    output logic [31:0] Instruction,
    output logic        Insthit,
    output logic        fetch_busywait
);

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_SQUASH = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] pend_target;
    logic [31:0] pend_target_next;
    logic [31:0] pc_inc;
    logic        hit;

    assign hit    = ~imem_busywait;
    assign pc_inc = fetch_pc + PC_INC;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_RESET;
            fetch_pc    <= RESET_PC;
            pend_target <= 32'h0000_0000;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            pend_target <= pend_target_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // fetch_pc only moves on a hit, so the memory address is stable for
    // the whole duration of a miss.
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        pend_target_next = pend_target;
        case (state)
            ST_RESET: begin
                state_next = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                if (hit) begin
                    state_next = ST_FETCH;
                    // A redirect seen under stall is held by upstream and
                    // taken once the stall drops.
                    if (!stall) begin
                        fetch_pc_next = redirect ? redirect_target : pc_inc;
                    end
                end else if (redirect) begin
                    // The outstanding word is now wrong-path; remember
                    // where to go once the memory finishes.
                    pend_target_next = redirect_target;
                    state_next       = ST_SQUASH;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_SQUASH: begin
                if (hit) begin
                    // Returned word is discarded, so stall does not matter:
                    // only a bubble enters IF/ID.
                    fetch_pc_next = redirect ? redirect_target : pend_target;
                    state_next    = ST_FETCH;
                end else if (redirect) begin
                    pend_target_next = redirect_target;
                end
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    assign imem_address = fetch_pc;
    assign PC           = fetch_pc;
    assign nextPC       = pc_inc;

    always_comb begin
        imem_read      = 1'b0;
        Instruction    = 32'h0000_0000;
        Insthit        = 1'b0;
        fetch_busywait = 1'b0;
        if (state != ST_RESET) begin
            imem_read      = 1'b1;
            Instruction    = imem_readdata;
            Insthit        = hit && !redirect && (state != ST_SQUASH);
            fetch_busywait = imem_busywait;
        end
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage directly upstream of the IF/ID pipeline register: holds the fetch PC, drives the instruction-memory/I-cache read handshake, and presents PC, nextPC, Instruction and Insthit to IF/ID.
- Takes taken-branch/jump redirects from the ALU stage and a downstream stall.
- Handles misses and redirects that arrive during an outstanding miss.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- PC_INC, 4, sequential PC increment in bytes.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clock.
- stall  in  1  downstream hold (data-memory busywait); PC must not advance.
- redirect  in  1  taken branch/jump resolved in the ALU stage.
- redirect_target  in  32  byte address to fetch after a redirect.
- imem_read  out  1  instruction-memory read request.
- imem_address  out  32  equals the fetch PC register.
- imem_readdata  in  32  instruction word; valid when imem_read=1 and imem_busywait=0.
- imem_busywait  in  1  miss in progress; data not yet valid.
- PC  out  32  address of the instruction presented.
- nextPC  out  32  PC+PC_INC, mod 2^32.
- Instruction  out  32  fetched word.
- Insthit  out  1  Instruction is valid, correct-path and presented this cycle.
- fetch_busywait  out  1  holds the IF/ID register.

Behaviour:
- Registers:
  - fetch_pc[31:0].
  - state in {RESET, FETCH, WAIT, SQUASH}.
  - pend_target[31:0].
- Reset (reset==0 at posedge):
  - fetch_pc<=RESET_PC, state<=RESET, pend_target<=0.
  - Applies from any state, including mid-miss; the outstanding memory transaction is abandoned, and the memory is reset by the same signal.
- Outputs in RESET:
  - imem_read=0, Insthit=0, fetch_busywait=0, Instruction=0.
  - PC=fetch_pc, nextPC=fetch_pc+PC_INC.
- RESET -> FETCH on the first posedge with reset==1. The first request is therefore issued one cycle after release.
- In FETCH/WAIT/SQUASH:
  - imem_read=1, imem_address=fetch_pc.
  - PC=fetch_pc, nextPC=fetch_pc+PC_INC (wraps), Instruction=imem_readdata.
  - fetch_busywait=imem_busywait.
- hit = imem_busywait==0.
- Insthit = hit && !redirect && state!=SQUASH.
- Wrong-path instructions already in later pipeline registers are flushed elsewhere, not by this block.
- FETCH:
  - hit & !stall: fetch_pc <= redirect ? redirect_target : fetch_pc+PC_INC; stay FETCH.
  - hit & stall: hold fetch_pc; stay FETCH. Insthit remains 1 and the same word is re-presented. Redirect is held asserted by upstream and is taken when stall drops.
  - miss & !redirect: -> WAIT; fetch_pc held.
  - miss & redirect: pend_target<=redirect_target; -> SQUASH.
- WAIT:
  - miss: fetch_pc held, so the address stays stable.
  - miss & redirect: pend_target<=redirect_target; -> SQUASH.
  - hit: same update as FETCH hit (stall and redirect rules identical); -> FETCH.
- SQUASH:
  - miss: hold. A new redirect overwrites pend_target (latest wins).
  - hit: returned word discarded (Insthit=0, fetch_busywait=0, so a bubble enters IF/ID). fetch_pc <= redirect ? redirect_target : pend_target, regardless of stall; -> FETCH.
- imem_address never changes while imem_busywait==1.
- Latency: one instruction per cycle on consecutive hits; a miss of N busy cycles adds N cycles.
- Redirect costs 0 extra cycles on a hit; during a miss it costs the remaining miss time plus 1 cycle.

Test Plan:
1. reset=0 for 2 cycles, then 1, with the memory always hitting (readdata=address) -> 1 cycle in RESET (imem_read=0, Insthit=0); then PC=0,4,8,12 on consecutive cycles, Instruction=PC, nextPC=PC+4, Insthit=1.
2. Miss at PC=0x8 with imem_busywait=1 for 3 cycles -> fetch_busywait=1 and imem_address=0x8 for 3 cycles, Insthit=0; 4th cycle Insthit=1, Instruction valid; next PC=0xC.
3. Hit at PC=0x10 with redirect=1, target=0x40 -> Insthit=0 that cycle; next cycle PC=0x40, Insthit=1.
4. Miss at 0x20 (busy 4 cycles) with redirect target 0x80 in busy cycle 2 -> state SQUASH, address stays 0x20; on the hit cycle Insthit=0, fetch_busywait=0; next cycle PC=0x80.
5. Hit at PC=0x4 with stall=1 for 2 cycles -> PC=0x4 and Insthit=1 held for both cycles; PC=0x8 the cycle after stall drops.
6. reset=0 during a miss at 0x20 -> next cycle state RESET, PC=0, imem_read=0, Insthit=0; fetch resumes at 0x0 after release.
